// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Round-robin arbiter and access sequencer placing two masters (CPU/DMA)
//   onto the 8-bit asynchronous SRAM bridge. Each granted request becomes
//   one SRAM cycle: SETUP (address/chip-select), ACCESS (strobe low for
//   WAIT_CYCLES cycles), DONE (hold + 1-cycle ack), then back to IDLE.
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_mN_req/we/addr/wdata  master N request (held until ack)
//   o_mN_ack              1-cycle completion pulse for master N
//   o_mN_rdata            read data for master N, valid from its ack
//   o_s_*                 active-low strobes, address and write data to bridge
//   i_s_readdata          read data from bridge
module sram_arbiter #(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2   // 1..15
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic              o_m0_ack,
  output logic [DATA_W-1:0] o_m0_rdata,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m1_ack,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_s_chipselect_n,
  output logic              o_s_byteenable_n,
  output logic              o_s_write_n,
  output logic              o_s_read_n,
  output logic [ADDR_W-1:0] o_s_address,
  output logic [DATA_W-1:0] o_s_writedata,
  input  logic [DATA_W-1:0] i_s_readdata
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [3:0] LP_WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_last;   // master granted most recently (1 = m1)
  logic              r_gnt;    // master owning the current access
  logic              r_we;
  logic              r_cs_n;
  logic              r_we_n;
  logic              r_rd_n;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ack0;
  logic              r_ack1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  // Winner: a lone requester always wins; on a tie the master that was not
  // granted last time wins.
  logic              w_gnt;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  assign w_gnt   = (i_m0_req & i_m1_req) ? ~r_last : i_m1_req;
  assign w_we    = w_gnt ? i_m1_we    : i_m0_we;
  assign w_addr  = w_gnt ? i_m1_addr  : i_m0_addr;
  assign w_wdata = w_gnt ? i_m1_wdata : i_m0_wdata;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_last   <= 1'b1;
      r_gnt    <= 1'b0;
      r_we     <= 1'b0;
      r_cs_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_rd_n   <= 1'b1;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      // acks are single-cycle pulses raised only on the ACCESS->DONE edge
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_m0_req | i_m1_req) begin
            r_state <= SETUP;
            r_gnt   <= w_gnt;
            r_last  <= w_gnt;
            r_we    <= w_we;
            r_addr  <= w_addr;
            if (w_we) r_wdata <= w_wdata;
            r_cs_n  <= 1'b0;
          end
        end
        SETUP: begin
          r_state <= ACCESS;
          r_cnt   <= LP_WAIT_LAST;
          r_we_n  <= ~r_we;
          r_rd_n  <= r_we;
        end
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state <= DONE;
            r_we_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            r_ack0  <= ~r_gnt;
            r_ack1  <= r_gnt;
            // sample the bridge while read_n is still low
            if (!r_we) begin
              if (r_gnt) r_rdata1 <= i_s_readdata;
              else       r_rdata0 <= i_s_readdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          // chip select, address and data held through DONE for hold time
          r_state <= IDLE;
          r_cs_n  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_m0_ack         = r_ack0;
  assign o_m1_ack         = r_ack1;
  assign o_m0_rdata       = r_rdata0;
  assign o_m1_rdata       = r_rdata1;
  assign o_s_chipselect_n = r_cs_n;
  assign o_s_byteenable_n = r_cs_n;
  assign o_s_write_n      = r_we_n;
  assign o_s_read_n       = r_rd_n;
  assign o_s_address      = r_addr;
  assign o_s_writedata    = r_wdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Directed and randomized bench for sram_arbiter. The reference model
//   works per transaction: a grant at cycle g owns the bus for cycles
//   g+1..g+2+W, strobes low g+2..g+1+W, ack at g+2+W. A second instance
//   built with WAIT_CYCLES=1 covers the shortest access.
module tb_sram_arbiter;
  localparam int W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [1:0]        req, we;
  logic [1:0][16:0]  addr;
  logic [1:0][7:0]   wd;
  logic              ack0, ack1, cs_n, be_n, we_n, rd_n;
  logic [7:0]        rdata0, rdata1, s_wd, s_rd;
  logic [16:0]       s_addr;

  // bridge model: data is a function of address, driven only while read_n low
  function automatic logic [7:0] rd_fn(input logic [16:0] a);
    return a[7:0] ^ 8'hD3;
  endfunction
  assign s_rd = rd_n ? 8'h00 : rd_fn(s_addr);

  sram_arbiter #(.ADDR_W(17), .DATA_W(8), .WAIT_CYCLES(W)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m0_req(req[0]), .i_m0_we(we[0]), .i_m0_addr(addr[0]), .i_m0_wdata(wd[0]),
    .o_m0_ack(ack0), .o_m0_rdata(rdata0),
    .i_m1_req(req[1]), .i_m1_we(we[1]), .i_m1_addr(addr[1]), .i_m1_wdata(wd[1]),
    .o_m1_ack(ack1), .o_m1_rdata(rdata1),
    .o_s_chipselect_n(cs_n), .o_s_byteenable_n(be_n), .o_s_write_n(we_n),
    .o_s_read_n(rd_n), .o_s_address(s_addr), .o_s_writedata(s_wd),
    .i_s_readdata(s_rd));

  // WAIT_CYCLES = 1 instance; master 1 tied idle
  logic        d1_req, d1_ack, d1_ack1, d1_cs_n, d1_be_n, d1_we_n, d1_rd_n;
  logic [16:0] d1_addr, d1_s_addr;
  logic [7:0]  d1_rdata, d1_rdata1, d1_s_wd, d1_s_rd;
  assign d1_s_rd = d1_rd_n ? 8'h00 : rd_fn(d1_s_addr);

  sram_arbiter #(.ADDR_W(17), .DATA_W(8), .WAIT_CYCLES(1)) dut1 (
    .i_clk(clk), .i_reset(rst),
    .i_m0_req(d1_req), .i_m0_we(1'b0), .i_m0_addr(d1_addr), .i_m0_wdata(8'h00),
    .o_m0_ack(d1_ack), .o_m0_rdata(d1_rdata),
    .i_m1_req(1'b0), .i_m1_we(1'b0), .i_m1_addr(17'h0), .i_m1_wdata(8'h00),
    .o_m1_ack(d1_ack1), .o_m1_rdata(d1_rdata1),
    .o_s_chipselect_n(d1_cs_n), .o_s_byteenable_n(d1_be_n), .o_s_write_n(d1_we_n),
    .o_s_read_n(d1_rd_n), .o_s_address(d1_s_addr), .o_s_writedata(d1_s_wd),
    .i_s_readdata(d1_s_rd));

  int vecs = 0, errs = 0;
  int cyc_n = 0, acks = 0, lastg = 1;
  bit tx_act = 0, tx_we = 0;
  int tx_m = 0, tx_g = 0, tx_end = -1;
  logic [16:0] tx_addr;
  logic [7:0]  tx_wd;
  int req_start[2] = '{0, 0};
  int ack_c[2] = '{-10, -10};
  int gq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic raise(input int m, input bit w_e, input logic [16:0] a, input logic [7:0] d);
    req[m] = 1'b1; we[m] = w_e; addr[m] = a; wd[m] = d; req_start[m] = cyc_n;
  endtask

  // One clock: model grant decision on the current inputs, then check outputs.
  task automatic tick();
    int w;
    bit inwin, strobe;
    if (rst) begin
      tx_act = 0; lastg = 1;
    end else if (!(tx_act && cyc_n <= tx_end)) begin
      tx_act = 0;
      if (req != 2'b00) begin
        if (req == 2'b11) w = 1 - lastg;
        else              w = req[1] ? 1 : 0;
        lastg = w; tx_act = 1; tx_m = w; tx_g = cyc_n; tx_end = cyc_n + 2 + W;
        tx_we = we[w]; tx_addr = addr[w]; tx_wd = wd[w];
        gq.push_back(w);
      end
    end
    @(posedge clk); #1; cyc_n++;
    inwin  = tx_act && cyc_n > tx_g && cyc_n <= tx_end;
    strobe = inwin && cyc_n >= tx_g + 2 && cyc_n <= tx_g + 1 + W;
    chk("cs_n", 32'(cs_n), 32'(!inwin));
    chk("be_n", 32'(be_n), 32'(!inwin));
    chk("we_n", 32'(we_n), 32'(!(strobe && tx_we)));
    chk("rd_n", 32'(rd_n), 32'(!(strobe && !tx_we)));
    chk("ack0", 32'(ack0), 32'(inwin && cyc_n == tx_end && tx_m == 0));
    chk("ack1", 32'(ack1), 32'(inwin && cyc_n == tx_end && tx_m == 1));
    if (inwin) chk("s_addr", 32'(s_addr), 32'(tx_addr));
    if (inwin && tx_we) chk("s_wdata", 32'(s_wd), 32'(tx_wd));
    acks += int'(ack0) + int'(ack1);
    if (inwin && cyc_n == tx_end) begin
      if (!tx_we) chk("rdata", 32'(tx_m == 1 ? rdata1 : rdata0), 32'(rd_fn(tx_addr)));
      chk("latency_bound", 32'((cyc_n - req_start[tx_m]) <= 2 * (3 + W)), 32'd1);
      req[tx_m] = 1'b0;
      ack_c[tx_m] = cyc_n;
    end
  endtask

  task automatic wait_ack(input string tag);
    int a0;
    a0 = acks;
    for (int i = 0; i < 30 && acks == a0; i++) tick();
    chk(tag, 32'(acks != a0), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  int t0, ack_at, rdlow;

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wd = '0;
    d1_req = 1'b0; d1_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_strobes", 32'({we_n, rd_n, be_n}), 32'h7);
    chk("rst_acks", 32'({ack0, ack1}), 32'd0);
    chk("rst_rdata", 32'({rdata0, rdata1}), 32'd0);
    chk("rst_addr", 32'(s_addr), 32'd0);
    chk("rst_wdata", 32'(s_wd), 32'd0);
    rst = 1'b0;

    // 1: m0 write, ack 4 cycles after req
    t0 = cyc_n;
    raise(0, 1'b1, 17'h1ABCD, 8'h5A);
    wait_ack("t1_ack");
    chk("t1_latency", 32'(ack_c[0] - t0), 32'd4);
    tick();

    // 2: m1 read of 0x00010 returns 0xC3
    t0 = cyc_n;
    raise(1, 1'b0, 17'h00010, 8'h00);
    wait_ack("t2_ack");
    chk("t2_latency", 32'(ack_c[1] - t0), 32'd4);
    chk("t2_rdata", 32'(rdata1), 32'hC3);
    tick();

    // 3: simultaneous requests after reset: m0 then m1
    do_reset();
    gq.delete();
    t0 = acks;
    raise(0, 1'b1, 17'h00123, 8'h11);
    raise(1, 1'b0, 17'h00456, 8'h22);
    for (int i = 0; i < 40 && acks < t0 + 2; i++) tick();
    chk("t3_acks", 32'(acks - t0), 32'd2);
    chk("t3_first", 32'(gq.size() > 0 ? gq[0] : -1), 32'd0);
    chk("t3_second", 32'(gq.size() > 1 ? gq[1] : -1), 32'd1);
    tick(); tick();

    // 4: both keep requesting; grants alternate
    gq.delete();
    for (int i = 0; i < 100 && gq.size() < 6; i++) begin
      for (int m = 0; m < 2; m++)
        if (!req[m] && cyc_n >= ack_c[m] + 2)
          raise(m, 1'(m), 17'($urandom), 8'($urandom));
      tick();
    end
    chk("t4_count", 32'(gq.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < gq.size(); i++)
      chk("t4_alternate", 32'(gq[i]), 32'(i % 2));
    for (int i = 0; i < 40 && (req != 2'b00 || (tx_act && cyc_n <= tx_end)); i++) tick();
    chk("t4_drain", 32'(req), 32'd0);
    tick();

    // 5: reset during ACCESS of a write, then normal completion
    t0 = acks;
    raise(0, 1'b1, 17'h00F0F, 8'hA5);
    tick(); tick();
    chk("t5_in_access", 32'(we_n), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_no_ack", 32'(acks - t0), 32'd0);
    wait_ack("t5_retry_ack");
    tick();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req[m] && cyc_n >= ack_c[m] + 2 && $urandom_range(2) == 0)
          raise(m, 1'($urandom_range(1)), 17'($urandom), 8'($urandom));
        else if (req[m] && tx_act && tx_m == m && cyc_n > tx_g && $urandom_range(3) == 0) begin
          addr[m] = 17'($urandom); wd[m] = 8'($urandom); we[m] = 1'($urandom_range(1));
        end
      end
      tick();
    end
    for (int i = 0; i < 40 && (req != 2'b00 || (tx_act && cyc_n <= tx_end)); i++) tick();
    chk("rand_drain", 32'(req), 32'd0);

    // 6: WAIT_CYCLES = 1 read
    d1_req = 1'b1; d1_addr = 17'h0AA55;
    ack_at = -1; rdlow = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (!d1_rd_n) rdlow++;
      if (d1_ack && ack_at < 0) begin ack_at = k; d1_req = 1'b0; end
    end
    chk("t6_ack_cycle", 32'(ack_at), 32'd3);
    chk("t6_read_low", 32'(rdlow), 32'd1);
    chk("t6_rdata", 32'(d1_rdata), 32'h86);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
